// File: rtl/intersection_pkg.sv
// Shared state encodings and lamp decoding for the two-road intersection sequencer.
// Lamp vector order: {a_red, a_yellow, a_green, b_red, b_yellow, b_green, ped_walk}.
package intersection_pkg;

    typedef enum logic [3:0] {
        ST_FLASH  = 4'd0,
        ST_ARED_A = 4'd1,
        ST_A_RY   = 4'd2,
        ST_A_GRN  = 4'd3,
        ST_A_YEL  = 4'd4,
        ST_ARED_B = 4'd5,
        ST_B_RY   = 4'd6,
        ST_B_GRN  = 4'd7,
        ST_B_YEL  = 4'd8,
        ST_PED    = 4'd9
    } state_t;

    localparam int LAMP_W = 7;

    function automatic logic [LAMP_W-1:0] lamp_decode(input state_t s, input logic blink);
        logic [LAMP_W-1:0] l;
        l = '0;
        case (s)
            ST_FLASH:  l = {1'b0, blink, 1'b0, 1'b0, blink, 1'b0, 1'b0};
            ST_ARED_A: l = 7'b100_100_0;
            ST_A_RY:   l = 7'b110_100_0;
            ST_A_GRN:  l = 7'b001_100_0;
            ST_A_YEL:  l = 7'b010_100_0;
            ST_ARED_B: l = 7'b100_100_0;
            ST_B_RY:   l = 7'b100_110_0;
            ST_B_GRN:  l = 7'b100_001_0;
            ST_B_YEL:  l = 7'b100_010_0;
            ST_PED:    l = 7'b100_100_1;
            default:   l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Loadable phase down-counter; saturates at zero, load has priority over hold.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (!hold && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection sequencer: roads A/B plus pedestrian phase, flashing yellow when disabled.
// Moore machine; every lamp is decoded from the registered state and blink bit.
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int T_GREEN  = 8,
    parameter int T_YELLOW = 2,
    parameter int T_REDYEL = 1,
    parameter int T_ALLRED = 2,
    parameter int T_PED    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       ped_req,
    output logic       a_red,
    output logic       a_yellow,
    output logic       a_green,
    output logic       b_red,
    output logic       b_yellow,
    output logic       b_green,
    output logic       ped_walk,
    output logic [3:0] state_out
);

    state_t r_state;
    state_t w_next;
    logic   r_blink;
    logic   r_lat_a;
    logic   r_lat_b;
    logic   r_lat_p;

    logic             w_zero;
    logic             w_load;
    logic             w_hold;
    logic [CNT_W-1:0] w_load_val;
    logic [LAMP_W-1:0] w_lamps;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .hold     (w_hold),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FLASH;
        end else begin
            r_state <= w_next;
        end
    end

    // Green is the only phase cut short when disabled; all others run out their timer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FLASH:  if (w_zero && enable) w_next = ST_ARED_A;
            ST_ARED_A: if (w_zero) w_next = enable ? ST_A_RY : ST_FLASH;
            ST_A_RY:   if (w_zero) w_next = ST_A_GRN;
            ST_A_GRN: begin
                if (!enable || (w_zero && (r_lat_b || r_lat_p))) w_next = ST_A_YEL;
            end
            ST_A_YEL:  if (w_zero) w_next = enable ? ST_ARED_B : ST_FLASH;
            ST_ARED_B: if (w_zero) w_next = enable ? ST_B_RY : ST_FLASH;
            ST_B_RY:   if (w_zero) w_next = ST_B_GRN;
            ST_B_GRN: begin
                if (!enable || (w_zero && (r_lat_a || r_lat_p))) w_next = ST_B_YEL;
            end
            ST_B_YEL: begin
                if (w_zero) begin
                    if (!enable)     w_next = ST_FLASH;
                    else if (r_lat_p) w_next = ST_PED;
                    else             w_next = ST_ARED_A;
                end
            end
            ST_PED:    if (w_zero) w_next = enable ? ST_ARED_A : ST_FLASH;
            default:   w_next = ST_FLASH;
        endcase
    end

    // Timer reloads on every state entry and on each blink half-period inside FLASH.
    always_comb begin
        w_load_val = '0;
        case (w_next)
            ST_FLASH:             w_load_val = CNT_W'(T_YELLOW - 1);
            ST_ARED_A, ST_ARED_B: w_load_val = CNT_W'(T_ALLRED - 1);
            ST_A_RY, ST_B_RY:     w_load_val = CNT_W'(T_REDYEL - 1);
            ST_A_GRN, ST_B_GRN:   w_load_val = CNT_W'(T_GREEN - 1);
            ST_A_YEL, ST_B_YEL:   w_load_val = CNT_W'(T_YELLOW - 1);
            ST_PED:               w_load_val = CNT_W'(T_PED - 1);
            default:              w_load_val = '0;
        endcase
    end

    assign w_load = (w_next != r_state) || ((r_state == ST_FLASH) && w_zero && !enable);
    assign w_hold = ((r_state == ST_A_GRN) || (r_state == ST_B_GRN)) && w_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink <= 1'b0;
        end else if (r_state != ST_FLASH || w_next != ST_FLASH) begin
            r_blink <= 1'b0;
        end else if (w_zero && !enable) begin
            r_blink <= ~r_blink;
        end
    end

    // A new request in the same cycle as the clearing entry keeps the latch set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat_a <= 1'b0;
            r_lat_b <= 1'b0;
            r_lat_p <= 1'b0;
        end else begin
            r_lat_a <= req_a   || (r_lat_a && !((w_next == ST_A_GRN) && (r_state != ST_A_GRN)));
            r_lat_b <= req_b   || (r_lat_b && !((w_next == ST_B_GRN) && (r_state != ST_B_GRN)));
            r_lat_p <= ped_req || (r_lat_p && !((w_next == ST_PED) && (r_state != ST_PED)));
        end
    end

    assign w_lamps = lamp_decode(r_state, r_blink);
    assign {a_red, a_yellow, a_green, b_red, b_yellow, b_green, ped_walk} = w_lamps;
    assign state_out = r_state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Table-driven bench for intersection_ctrl: run-length vectors of inputs and expected state/blink,
// with expected {state, lamps} pushed to a queue at drive time and popped after the clock edge.
module tb_intersection_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       req_a;
    logic       req_b;
    logic       ped_req;
    logic       a_red, a_yellow, a_green;
    logic       b_red, b_yellow, b_green;
    logic       ped_walk;
    logic [3:0] state_out;

    typedef struct {
        logic       rs;
        logic       en;
        logic       ra;
        logic       rb;
        logic       pd;
        int         n;
        logic [3:0] st;
        logic       bl;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] exp_q[$];
    int          tests_run;
    int          tests_failed;
    int          part1_end;

    intersection_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .req_a     (req_a),
        .req_b     (req_b),
        .ped_req   (ped_req),
        .a_red     (a_red),
        .a_yellow  (a_yellow),
        .a_green   (a_green),
        .b_red     (b_red),
        .b_yellow  (b_yellow),
        .b_green   (b_green),
        .ped_walk  (ped_walk),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference lamps {ar, ay, ag, br, by, bg, walk} for a given state and blink bit.
    function automatic logic [6:0] exp_lamps(input logic [3:0] s, input logic b);
        case (s)
            4'd0:       return {1'b0, b, 1'b0, 1'b0, b, 1'b0, 1'b0};
            4'd1, 4'd5: return 7'b1001000;
            4'd2:       return 7'b1101000;
            4'd3:       return 7'b0011000;
            4'd4:       return 7'b0101000;
            4'd6:       return 7'b1001100;
            4'd7:       return 7'b1000010;
            4'd8:       return 7'b1000100;
            4'd9:       return 7'b1001001;
            default:    return 7'b0000000;
        endcase
    endfunction

    task automatic add(input logic rs, input logic en, input logic ra, input logic rb,
                       input logic pd, input int n, input logic [3:0] st, input logic bl);
        vec_t v;
        v.rs = rs; v.en = en; v.ra = ra; v.rb = rb; v.pd = pd;
        v.n = n; v.st = st; v.bl = bl;
        vecs.push_back(v);
    endtask

    task automatic check_out(input string tag, input int idx);
        logic [10:0] got;
        logic [10:0] exp;
        got = {state_out, a_red, a_yellow, a_green, b_red, b_yellow, b_green, ped_walk};
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s #%0d: scoreboard empty, got state=%0d lamps=%b", tag, idx,
                     got[10:7], got[6:0]);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL %s #%0d: got state=%0d lamps=%b, expected state=%0d lamps=%b",
                         tag, idx, got[10:7], got[6:0], exp[10:7], exp[6:0]);
            end
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                @(negedge clk);
                rst     = vecs[i].rs;
                enable  = vecs[i].en;
                req_a   = vecs[i].ra;
                req_b   = vecs[i].rb;
                ped_req = vecs[i].pd;
                exp_q.push_back({vecs[i].st, exp_lamps(vecs[i].st, vecs[i].bl)});
                @(posedge clk);
                #1;
                check_out("vec", i);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1; enable = 1'b0; req_a = 1'b0; req_b = 1'b0; ped_req = 1'b0;

        // Fields: rst, enable, req_a, req_b, ped_req, cycles, expected state, expected blink.
        // Flashing from reset: blink toggles every two cycles.
        add(1, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0, 0, 2, 0, 1);
        // Enable, no requests: all-red, red+yellow, then green rest on A.
        add(0, 1, 0, 0, 0, 2, 1, 0);
        add(0, 1, 0, 0, 0, 1, 2, 0);
        add(0, 1, 0, 0, 0, 12, 3, 0);
        // Road B request from the A rest.
        add(0, 1, 0, 1, 0, 1, 3, 0);
        add(0, 1, 0, 0, 0, 2, 4, 0);
        add(0, 1, 0, 0, 0, 2, 5, 0);
        add(0, 1, 0, 0, 0, 1, 6, 0);
        add(0, 1, 0, 0, 0, 10, 7, 0);
        // Pedestrian pulse during B green; A then rests, so lat_b and lat_p are clear.
        add(0, 1, 0, 0, 1, 1, 7, 0);
        add(0, 1, 0, 0, 0, 2, 8, 0);
        add(0, 1, 0, 0, 0, 6, 9, 0);
        add(0, 1, 0, 0, 0, 2, 1, 0);
        add(0, 1, 0, 0, 0, 1, 2, 0);
        add(0, 1, 0, 0, 0, 12, 3, 0);
        // Disable on the third A green cycle, then re-enable mid blink half-period.
        add(1, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 2, 1, 0);
        add(0, 1, 0, 0, 0, 1, 2, 0);
        add(0, 1, 0, 0, 0, 3, 3, 0);
        add(0, 0, 0, 0, 0, 2, 4, 0);
        add(0, 0, 0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 2, 1, 0);
        add(0, 1, 0, 0, 0, 1, 2, 0);
        add(0, 1, 0, 0, 0, 2, 3, 0);
        // B and pedestrian requests together, run up to the first B yellow cycle.
        add(0, 1, 0, 1, 1, 1, 3, 0);
        add(0, 1, 0, 0, 0, 5, 3, 0);
        add(0, 1, 0, 0, 0, 2, 4, 0);
        add(0, 1, 0, 0, 0, 2, 5, 0);
        add(0, 1, 0, 0, 0, 1, 6, 0);
        add(0, 1, 0, 0, 0, 8, 7, 0);
        add(0, 1, 0, 0, 0, 1, 8, 0);
        part1_end = vecs.size();
        // After reset mid B yellow the pending pedestrian request is gone.
        add(1, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 2, 1, 0);
        add(0, 1, 0, 0, 0, 1, 2, 0);
        add(0, 1, 0, 0, 0, 12, 3, 0);

        #2;
        exp_q.push_back({4'd0, 7'b0000000});
        check_out("reset_initial", 0);

        run_vecs(0, part1_end);

        // Asynchronous reset takes effect before the next clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.push_back({4'd0, 7'b0000000});
        check_out("reset_async", 0);

        run_vecs(part1_end, vecs.size());

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
